// File: rtl/seq_detect_mealy_if.sv
// Serial stream interface for the 1011 detector: one data bit in, one match flag out.
interface seq_detect_mealy_if;
    logic i_seq;
    logic o_out;

    modport master (output i_seq, input  o_out);
    modport slave  (input  i_seq, output o_out);
endinterface

// File: rtl/seq_detect_mealy.sv
// Overlapping Mealy detector for the serial pattern 1-0-1-1 (first bit first).
// Match flag is combinational and valid in the cycle the final 1 is on i_seq.
module seq_detect_mealy (
    input  logic                 i_clk,
    input  logic                 i_rstn,  // active-high despite the name
    seq_detect_mealy_if.slave    bus
);

    typedef enum logic [1:0] {
        S0 = 2'd0,  // nothing matched
        S1 = 2'd1,  // "1"
        S2 = 2'd2,  // "10"
        S3 = 2'd3   // "101"
    } state_t;

    state_t state_q, state_d;
    logic   out_d;

    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) state_q <= S0;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S0;
        out_d   = 1'b0;
        case (state_q)
            S0: state_d = bus.i_seq ? S1 : S0;
            S1: state_d = bus.i_seq ? S1 : S2;
            S2: state_d = bus.i_seq ? S3 : S0;
            S3: begin
                // On a match keep the trailing "1"; on a 0 keep the suffix "10".
                state_d = bus.i_seq ? S1 : S2;
                out_d   = bus.i_seq;
            end
            default: begin
                state_d = S0;
                out_d   = 1'b0;
            end
        endcase
    end

    assign bus.o_out = out_d & ~i_rstn;

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Directed and random checks of the overlapping 1011 Mealy detector.
module tb_seq_detect_mealy;

    logic i_clk;
    logic i_rstn;
    int   checks;
    int   errors;

    seq_detect_mealy_if bus ();

    seq_detect_mealy dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .bus    (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Change i_seq at the falling edge; o_out is then sampled 2 ns later,
    // well before the rising edge that consumes the bit.
    task automatic drive_bit(input logic b);
        @(negedge i_clk);
        bus.i_seq = b;
        #2;
    endtask

    task automatic do_reset(input int n);
        @(negedge i_clk);
        i_rstn = 1'b1;
        bus.i_seq = 1'b0;
        repeat (n) @(negedge i_clk);
        i_rstn = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] pat;
        logic [3:0] exp;
        @(negedge i_clk);
        i_rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            bus.i_seq = i[0];
            #2;
            checks++;
            if (bus.o_out !== 1'b0 || dut.state_q !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: o_out=%b state=%0d, want o_out=0 state=0",
                         i, bus.o_out, dut.state_q);
            end
        end
        @(negedge i_clk);
        i_rstn = 1'b0;
        pat = 4'b1011;
        exp = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            bus.i_seq = pat[i];
            #2;
            checks++;
            if (bus.o_out !== exp[i]) begin
                errors++;
                $display("FAIL reset_first_pattern bit %0d: o_out=%b want %b", 4 - i, bus.o_out, exp[i]);
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] pat;
        logic [6:0] exp;
        do_reset(2);
        pat = 7'b1011011;
        exp = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            drive_bit(pat[i]);
            checks++;
            if (bus.o_out !== exp[i]) begin
                errors++;
                $display("FAIL overlap bit %0d: o_out=%b want %b", 7 - i, bus.o_out, exp[i]);
            end
        end
    endtask

    task automatic test_fallback();
        logic [5:0] pa, ea;
        logic [4:0] pb, eb;
        do_reset(2);
        pa = 6'b101011;
        ea = 6'b000001;
        for (int i = 5; i >= 0; i--) begin
            drive_bit(pa[i]);
            checks++;
            if (bus.o_out !== ea[i]) begin
                errors++;
                $display("FAIL fallback_s3_s2 bit %0d: o_out=%b want %b", 6 - i, bus.o_out, ea[i]);
            end
        end
        do_reset(2);
        pb = 5'b11011;
        eb = 5'b00001;
        for (int i = 4; i >= 0; i--) begin
            drive_bit(pb[i]);
            checks++;
            if (bus.o_out !== eb[i]) begin
                errors++;
                $display("FAIL fallback_s1_loop bit %0d: o_out=%b want %b", 5 - i, bus.o_out, eb[i]);
            end
        end
        do_reset(2);
        pb = 5'b10011;
        for (int i = 4; i >= 0; i--) begin
            drive_bit(pb[i]);
            checks++;
            if (bus.o_out !== 1'b0) begin
                errors++;
                $display("FAIL fallback_s2_s0 bit %0d: o_out=%b want 0", 5 - i, bus.o_out);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] pb;
        do_reset(2);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        // Keep a 1 on the input so the S3 match term would fire without reset.
        @(negedge i_clk);
        bus.i_seq = 1'b1;
        #1;
        checks++;
        if (bus.o_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_prereset: o_out=%b want 1", bus.o_out);
        end
        #1;
        i_rstn = 1'b1;
        #1;
        checks++;
        if (bus.o_out !== 1'b0 || dut.state_q !== 2'd0) begin
            errors++;
            $display("FAIL mid_async_reset: o_out=%b state=%0d want o_out=0 state=0",
                     bus.o_out, dut.state_q);
        end
        @(negedge i_clk);
        i_rstn = 1'b0;
        bus.i_seq = 1'b1;
        #2;
        checks++;
        if (bus.o_out !== 1'b0 || dut.state_q !== 2'd0) begin
            errors++;
            $display("FAIL mid_after_release: o_out=%b state=%0d want o_out=0 state=0",
                     bus.o_out, dut.state_q);
        end
        pb = 4'b0011;  // bits 0,1,1 then nothing; top bit unused
        for (int i = 2; i >= 0; i--) begin
            drive_bit(pb[i]);
            checks++;
            if (bus.o_out !== (i == 0)) begin
                errors++;
                $display("FAIL mid_restart bit %0d: o_out=%b want %b", 3 - i, bus.o_out, (i == 0));
            end
        end
    endtask

    task automatic test_degenerate();
        int bad0, bad1;
        do_reset(2);
        bad0 = 0;
        bad1 = 0;
        for (int i = 0; i < 20; i++) begin
            drive_bit(1'b0);
            if (bus.o_out !== 1'b0) bad0++;
        end
        checks++;
        if (bad0 != 0) begin
            errors++;
            $display("FAIL all_zero: %0d cycles with o_out!=0, want 0", bad0);
        end
        for (int i = 0; i < 20; i++) begin
            drive_bit(1'b1);
            if (bus.o_out !== 1'b0) bad1++;
        end
        checks++;
        if (bad1 != 0) begin
            errors++;
            $display("FAIL all_one: %0d cycles with o_out!=0, want 0", bad1);
        end
    endtask

    task automatic test_random();
        logic [3:0] hist;
        logic       b, exp;
        do_reset(4);
        hist = 4'b0000;
        for (int i = 0; i < 50; i++) begin
            b    = 1'($urandom_range(0, 1));
            hist = {hist[2:0], b};
            exp  = (hist == 4'b1011);
            drive_bit(b);
            checks++;
            if (bus.o_out !== exp) begin
                errors++;
                $display("FAIL random cyc %0d hist=%b: o_out=%b want %b", i, hist, bus.o_out, exp);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        i_rstn    = 1'b1;
        bus.i_seq = 1'b0;
        test_reset();
        test_overlap();
        test_fallback();
        test_reset_mid();
        test_degenerate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_mealy.md
# seq_detect_mealy

Serial bit-pattern detector built as a 4-state Mealy FSM. It samples one input bit per clock and asserts a combinational match flag during the cycle in which the last bit of the pattern 1-0-1-1 is present. Detection is overlapping. The block is a leaf in the FSM training set and is driven directly by a serial stimulus source.

## Interface
- No parameters. The pattern (1011, first-received bit first), its length (4) and overlap mode are fixed.
- i_clk  input  1  system clock; all state updates occur on the rising edge.
- i_rstn  input  1  asynchronous, active-high reset. The name is kept for codebase consistency, but 1 means reset asserted.
- i_seq  input  1  serial data bit, sampled on each rising edge of i_clk.
- o_out  output  1  match flag. It is 1 when the current i_seq bit completes 1011 with the three previously sampled bits.

## Operation
- State register, 2-bit binary encoding. Each state records the longest pattern prefix matched so far:
  - S0 (2'd0): nothing matched.
  - S1 (2'd1): "1" matched.
  - S2 (2'd2): "10" matched.
  - S3 (2'd3): "101" matched.
- Transitions, given as input -> next state / o_out:
  - S0: 0 -> S0/0; 1 -> S1/0.
  - S1: 0 -> S2/0; 1 -> S1/0.
  - S2: 0 -> S0/0; 1 -> S3/0.
  - S3: 0 -> S2/0 (the suffix "10" is retained); 1 -> S1/1 (match; the suffix "1" is retained for overlap).
- o_out is purely combinational: o_out = (state == S3) & i_seq & ~i_rstn. It has no register stage.
- Next-state logic is a combinational case on state. Any unreachable or unknown state value goes to S0 with o_out = 0.
- The FSM runs continuously. There is no enable and no handshake, and the stream has no start or end framing.

## Timing
- Reset: while i_rstn = 1, the state is held at S0 and o_out = 0, independent of the clock and of i_seq. Assertion takes effect immediately (asynchronously).
- After reset deasserts, the first rising edge with i_rstn = 0 samples the first stream bit.
- Reset asserted mid-sequence discards any partial match. After release, detection restarts from S0, so a pattern that began before reset is never reported.
- Latency: zero cycles. o_out goes high in the same clock period in which the fourth pattern bit is on i_seq, settling after i_seq and state settle.
- o_out is sampled by downstream logic at the rising edge that also consumes that bit. It lasts exactly one cycle per match unless the next match overlaps.
- With overlap, 1011011 produces matches on bits 4 and 7. The shortest match spacing is 3 bits, because consecutive matches share the trailing "1".
- i_seq must be stable around each rising edge. The bench changes it mid-period (clock period 10 ns; i_seq updated at the falling edge).
- o_out may glitch while i_seq changes mid-cycle. Consumers use it synchronously only.

## Test plan
- Reset behaviour: hold i_rstn = 1 for 4 cycles while toggling i_seq. Required: o_out = 0 throughout and state = S0. Release reset, apply 1,0,1,1. Required: o_out = 1 only during the 4th bit.
- Overlapping matches: apply 1,0,1,1,0,1,1. Required: o_out = 1 during bits 4 and 7 and 0 on every other bit.
- Fallback paths: apply 1,0,1,0,1,1 (S3 -> S2 on 0). Required: single pulse on bit 6. Apply 1,1,0,1,1 (S1 self-loop). Required: pulse on bit 5. Apply 1,0,0,1,1. Required: no pulse.
- Reset mid-pattern: apply 1,0,1, assert i_rstn asynchronously between edges for one cycle, release, then apply 1. Required: o_out = 0 and state = S0 on the next edge. Then apply 0,1,1. Required: pulse on the final 1.
- Degenerate streams: 20 cycles of all 0 and then 20 cycles of all 1. Required: o_out = 0 throughout.
- Random soak: 50 cycles of $urandom_range(0,1) after a 4-cycle reset. Compare o_out each cycle against a 4-bit shift-register reference model (match when the last four bits, oldest first, are 1011). Required: zero mismatches.
